// File: rtl/bin_to_seg_conv_if.sv
// Handshake bundle between the calculator datapath and the
// binary-to-7-segment converter.
interface bin_to_seg_conv_if #(
  parameter int DATA_W = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [DATA_W-1:0]     data;
  logic [DIGITS-1:0]     dp_mask;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [8*DIGITS-1:0]   code;

  modport master (
    output start,
    output data,
    output dp_mask,
    input  busy,
    input  done,
    input  ovf,
    input  code
  );

  modport slave (
    input  start,
    input  data,
    input  dp_mask,
    output busy,
    output done,
    output ovf,
    output code
  );
endinterface

// File: rtl/bin_to_seg_conv.sv
// Sequential binary-to-7-segment converter, one double-dabble
// step per clock, with zero blanking, decimal points and overflow.
module bin_to_seg_conv #(
  parameter int DATA_W = 12,
  parameter int DIGITS = 4,
  parameter bit LZB    = 1'b1
) (
  input logic             clk,
  input logic             rst,
  bin_to_seg_conv_if.slave bus
);
  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int CMP_W = (DATA_W + 1 > BW) ? DATA_W + 1 : BW;
  localparam logic [CMP_W-1:0] LIMIT = CMP_W'(10 ** DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    OUT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   sh_q;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       bcd_adj;
  logic [DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovfp_q;
  logic                ovf_q;
  logic                done_q;
  logic [8*DIGITS-1:0] code_q;
  logic [8*DIGITS-1:0] code_d;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hfc;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hda;
      4'd3:    s = 8'hf2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hb6;
      4'd6:    s = 8'hbe;
      4'd7:    s = 8'he0;
      4'd8:    s = 8'hfe;
      4'd9:    s = 8'hf6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(1)) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  // Walk from the top digit down; a digit blanks only while
  // everything above it is also zero.
  always_comb begin : enc
    logic       zero_hi;
    logic       blank;
    logic [3:0] nib;
    logic [7:0] byte_v;
    code_d  = '0;
    zero_hi = 1'b1;
    blank   = 1'b0;
    nib     = '0;
    byte_v  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib     = bcd_q[4*i +: 4];
      zero_hi = zero_hi && (nib == 4'd0);
      blank   = LZB && (i != 0) && zero_hi;
      if (ovfp_q)     byte_v = 8'h02;
      else if (blank) byte_v = 8'h00;
      else            byte_v = seg(nib);
      code_d[8*i +: 8] = byte_v | {7'd0, dp_q[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      dp_q   <= '0;
      cnt_q  <= '0;
      ovfp_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      code_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_q   <= bus.data;
            bcd_q  <= '0;
            dp_q   <= bus.dp_mask;
            cnt_q  <= CNT_W'(DATA_W);
            ovfp_q <= CMP_W'(bus.data) >= LIMIT;
          end
        end
        CONV: begin
          bcd_q <= {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        OUT: begin
          code_q <= code_d;
          ovf_q  <= ovfp_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.code = code_q;
endmodule

// File: tb/tb_bin_to_seg_conv.sv
// Bench for bin_to_seg_conv: three builds (4 digits, 3 digits,
// 4 digits without blanking) against an arithmetic digit model.
module tb_bin_to_seg_conv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  localparam logic [7:0] SEGT [10] = '{8'hfc, 8'h60, 8'hda, 8'hf2,
    8'h66, 8'hb6, 8'hbe, 8'he0, 8'hfe, 8'hf6};

  always #5 clk = ~clk;

  bin_to_seg_conv_if #(.DATA_W(12), .DIGITS(4)) if4 ();
  bin_to_seg_conv_if #(.DATA_W(12), .DIGITS(3)) if3 ();
  bin_to_seg_conv_if #(.DATA_W(12), .DIGITS(4)) ifz ();

  bin_to_seg_conv #(.DATA_W(12), .DIGITS(4), .LZB(1'b1)) u4 (
    .clk(clk), .rst(rst), .bus(if4.slave));
  bin_to_seg_conv #(.DATA_W(12), .DIGITS(3), .LZB(1'b1)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave));
  bin_to_seg_conv #(.DATA_W(12), .DIGITS(4), .LZB(1'b0)) uz (
    .clk(clk), .rst(rst), .bus(ifz.slave));

  // Expected display straight from decimal arithmetic.
  function automatic logic [31:0] model(input int v, input int n,
                                        input bit lzb,
                                        input logic [3:0] dp);
    logic [31:0] r;
    logic [7:0]  b;
    int          p;
    int          lim;
    r   = '0;
    lim = 1;
    for (int i = 0; i < n; i++) lim *= 10;
    p = 1;
    for (int i = 0; i < n; i++) begin
      if (v >= lim)                     b = 8'h02;
      else if (lzb && i > 0 && v < p)   b = 8'h00;
      else                              b = SEGT[(v / p) % 10];
      r[8*i +: 8] = b | {7'd0, dp[i]};
      p *= 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int w);
    return (w == 1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] code_of(input int w);
    case (w)
      0:       return if4.code;
      1:       return {8'h00, if3.code};
      default: return ifz.code;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return if4.done;
      1:       return if3.done;
      default: return ifz.done;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0:       return if4.busy;
      1:       return if3.busy;
      default: return ifz.busy;
    endcase
  endfunction

  function automatic logic ovf_of(input int w);
    case (w)
      0:       return if4.ovf;
      1:       return if3.ovf;
      default: return ifz.ovf;
    endcase
  endfunction

  task automatic drive(input int w, input logic s,
                       input logic [11:0] d, input logic [3:0] m);
    case (w)
      0: begin if4.start = s; if4.data = d; if4.dp_mask = m; end
      1: begin if3.start = s; if3.data = d; if3.dp_mask = m[2:0]; end
      default: begin ifz.start = s; ifz.data = d; ifz.dp_mask = m; end
    endcase
  endtask

  // One-cycle start pulse, then wait (bounded) for done.
  task automatic run(input int w, input logic [11:0] d,
                     input logic [3:0] m, output int lat,
                     output int bc, output bit to);
    @(posedge clk); #1;
    drive(w, 1'b1, d, m);
    @(posedge clk); #1;
    drive(w, 1'b0, d, m);
    lat = 0;
    bc  = 0;
    while (!done_of(w) && lat < 40) begin
      if (busy_of(w)) bc++;
      @(posedge clk); #1;
      lat++;
    end
    to = !done_of(w);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({busy_of(w), done_of(w), ovf_of(w), code_of(w)} !== 35'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got b=%b d=%b o=%b c=%h want 0",
                 w, busy_of(w), done_of(w), ovf_of(w), code_of(w));
      end
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_vectors;
    int lat, bc;
    bit to;
    run(0, 12'd123, 4'b0000, lat, bc, to);
    checks++;
    if (to || lat != 13) begin
      errors++;
      $display("FAIL latency_123: got %0d (timeout=%0d) want 13", lat, to);
    end
    checks++;
    if (bc != 13) begin
      errors++;
      $display("FAIL busy_len_123: got %0d want 13", bc);
    end
    checks++;
    if (if4.code !== 32'h0060daf2 || if4.ovf !== 1'b0) begin
      errors++;
      $display("FAIL code_123: got %h ovf=%b want 0060daf2 ovf=0",
               if4.code, if4.ovf);
    end
    checks++;
    if (if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b want 0", if4.busy);
    end
    run(0, 12'd0, 4'b0000, lat, bc, to);
    checks++;
    if (to || if4.code !== 32'h000000fc) begin
      errors++;
      $display("FAIL code_zero: got %h want 000000fc", if4.code);
    end
    run(2, 12'd7, 4'b0000, lat, bc, to);
    checks++;
    if (to || ifz.code !== 32'hfcfcfce0) begin
      errors++;
      $display("FAIL code_nolzb_7: got %h want fcfcfce0", ifz.code);
    end
    run(1, 12'd4095, 4'b0000, lat, bc, to);
    checks++;
    if (to || if3.code !== 24'h020202 || if3.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_4095: got %h ovf=%b want 020202 ovf=1",
               if3.code, if3.ovf);
    end
    run(1, 12'd999, 4'b0000, lat, bc, to);
    checks++;
    if (to || if3.code !== 24'hf6f6f6 || if3.ovf !== 1'b0) begin
      errors++;
      $display("FAIL code_999: got %h ovf=%b want f6f6f6 ovf=0",
               if3.code, if3.ovf);
    end
    run(0, 12'd45, 4'b0010, lat, bc, to);
    checks++;
    if (to || if4.code !== 32'h000067b6) begin
      errors++;
      $display("FAIL code_45_dp: got %h want 000067b6", if4.code);
    end
  endtask

  task automatic test_random;
    int lat, bc, w, v, n;
    bit to;
    logic [3:0] m;
    logic [31:0] exp_c;
    bit exp_o;
    int edges [8] = '{0, 9, 10, 99, 100, 999, 1000, 4095};
    for (int k = 0; k < 40; k++) begin
      w = k % 3;
      n = ndig(w);
      v = (k < 8) ? edges[k] : int'($urandom_range(0, 4095));
      m = 4'($urandom_range(0, 15));
      if (n == 3) m[3] = 1'b0;
      run(w, 12'(v), m, lat, bc, to);
      exp_c = model(v, n, w != 2, m);
      exp_o = (n == 3) ? (v >= 1000) : (v >= 10000);
      checks++;
      if (to || code_of(w) !== exp_c || ovf_of(w) !== exp_o
          || lat != 13) begin
        errors++;
        $display("FAIL rand dut%0d v=%0d dp=%b: got %h ovf=%b lat=%0d want %h ovf=%b lat=13",
                 w, v, m, code_of(w), ovf_of(w), lat, exp_c, exp_o);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int nd;
    logic [31:0] seen;
    bit held;
    @(posedge clk); #1;
    drive(0, 1'b1, 12'd5, 4'b0000);
    @(posedge clk); #1;
    drive(0, 1'b0, 12'd5, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 1'b1, 12'd9, 4'b1111);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1'b0, 12'd9, 4'b1111);
    nd   = 0;
    seen = '0;
    for (int c = 0; c < 30; c++) begin
      if (if4.done) begin
        nd++;
        seen = if4.code;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 1 || seen !== 32'h000000b6) begin
      errors++;
      $display("FAIL busy_ignore: got dones=%0d code=%h want 1 000000b6",
               nd, seen);
    end
    held = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (if4.code !== 32'h000000b6 || if4.done !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL code_hold: got code=%h done=%b want 000000b6 0",
               if4.code, if4.done);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, cyc;
    logic [31:0] c1, c2;
    t1 = -1;
    t2 = -1;
    c1 = '0;
    c2 = '0;
    @(posedge clk); #1;
    drive(0, 1'b1, 12'd2024, 4'b0000);
    @(posedge clk); #1;
    cyc = 0;
    while (t2 < 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (if4.done) begin
        if (t1 < 0) begin
          t1 = cyc;
          c1 = if4.code;
          drive(0, 1'b1, 12'd8, 4'b0001);
        end else begin
          t2 = cyc;
          c2 = if4.code;
          drive(0, 1'b0, 12'd8, 4'b0001);
        end
      end
    end
    drive(0, 1'b0, 12'd0, 4'b0000);
    checks++;
    if (t1 != 13 || t2 != 27) begin
      errors++;
      $display("FAIL b2b_timing: got done at %0d,%0d want 13,27", t1, t2);
    end
    checks++;
    if (c1 !== model(2024, 4, 1'b1, 4'b0000)
        || c2 !== model(8, 4, 1'b1, 4'b0001)) begin
      errors++;
      $display("FAIL b2b_codes: got %h,%h want %h,%h", c1, c2,
               model(2024, 4, 1'b1, 4'b0000), model(8, 4, 1'b1, 4'b0001));
    end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int nd, lat, bc;
    bit to;
    @(posedge clk); #1;
    drive(0, 1'b1, 12'd123, 4'b0000);
    @(posedge clk); #1;
    drive(0, 1'b0, 12'd123, 4'b0000);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({if4.busy, if4.done, if4.ovf, if4.code} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid: got b=%b d=%b o=%b c=%h want 0",
               if4.busy, if4.done, if4.ovf, if4.code);
    end
    #2 rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (if4.done || if4.busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d active cycles want 0", nd);
    end
    run(0, 12'd321, 4'b0100, lat, bc, to);
    checks++;
    if (to || if4.code !== model(321, 4, 1'b1, 4'b0100) || lat != 13) begin
      errors++;
      $display("FAIL after_reset: got %h lat=%0d want %h lat=13",
               if4.code, lat, model(321, 4, 1'b1, 4'b0100));
    end
  endtask

  initial begin
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 12'd0, 4'b0000);
    test_reset;
    test_vectors;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
